// File: rtl/timer_pkg.sv
// Shared types and helpers for the game countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Binary 0-99 to {tens, ones} BCD; used only for elaboration-time constants.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with parallel load and a combinational borrow out.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter bcd_digit_t WRAP = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       dec,
  output bcd_digit_t digit,
  output logic       borrow_out
);

  assign borrow_out = dec && (digit == 4'd0);

  always_ff @(posedge clock) begin
    if (reset || load)
      digit <= load_val;
    else if (dec)
      digit <= (digit == 4'd0) ? WRAP : digit - 4'd1;
  end

endmodule

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown driven by a 1 Hz tick; reports expiry to game control.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned START_MIN = 2,
  parameter int unsigned START_SEC = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       expire_pulse
);

  localparam logic [15:0] RELOAD = {to_bcd(START_MIN), to_bcd(START_SEC)};

  timer_state_t    state;
  logic [3:0][3:0] digits;
  logic [4:0]      chain;
  logic            chain_unused;
  logic            at_zero, at_one, load;

  assign at_zero = (digits == 16'h0000);
  assign at_one  = (digits == 16'h0001);
  // Never decrement past 00:00 (reachable when restarting from a 00:00 reload).
  assign chain[0] = (state == RUN) && tick && !at_zero;
  assign load     = clear || ((state == EXPIRED) && start);

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_down_digit #(.WRAP((i == 1) ? 4'd5 : 4'd9)) u_digit (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .load_val   (RELOAD[4*i +: 4]),
      .dec        (chain[i]),
      .digit      (digits[i]),
      .borrow_out (chain[i+1])
    );
  end

  assign chain_unused = chain[4];
  assign min_bcd = digits[3:2];
  assign sec_bcd = digits[1:0];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state        <= IDLE;
      running      <= 1'b0;
      expired      <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      expire_pulse <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (at_zero) begin
            state <= EXPIRED; expired <= 1'b1; expire_pulse <= 1'b1;
          end else begin
            state <= RUN; running <= 1'b1;
          end
        end
        RUN: begin
          // Expiry wins over a simultaneous pause.
          if ((tick && at_one) || at_zero) begin
            state <= EXPIRED; running <= 1'b0; expired <= 1'b1; expire_pulse <= 1'b1;
          end else if (pause) begin
            state <= PAUSED; running <= 1'b0;
          end
        end
        PAUSED: if (start && !pause) begin
          state <= RUN; running <= 1'b1;
        end
        EXPIRED: if (start) begin
          state <= RUN; running <= 1'b1; expired <= 1'b0;
        end
        default: begin
          state <= IDLE; running <= 1'b0; expired <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scenarios against several parameterisations of countdown_timer.
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] tick = '0, start = '0, pause = '0, clear = '0;
  logic [7:0] min_b [5];
  logic [7:0] sec_b [5];
  logic [4:0] running, expired, xp;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  countdown_timer #(.START_MIN(2),  .START_SEC(0)) u0 (.clock(clock), .reset(reset), .tick(tick[0]), .start(start[0]),
    .pause(pause[0]), .clear(clear[0]), .min_bcd(min_b[0]), .sec_bcd(sec_b[0]), .running(running[0]),
    .expired(expired[0]), .expire_pulse(xp[0]));
  countdown_timer #(.START_MIN(0),  .START_SEC(1)) u1 (.clock(clock), .reset(reset), .tick(tick[1]), .start(start[1]),
    .pause(pause[1]), .clear(clear[1]), .min_bcd(min_b[1]), .sec_bcd(sec_b[1]), .running(running[1]),
    .expired(expired[1]), .expire_pulse(xp[1]));
  countdown_timer #(.START_MIN(10), .START_SEC(0)) u2 (.clock(clock), .reset(reset), .tick(tick[2]), .start(start[2]),
    .pause(pause[2]), .clear(clear[2]), .min_bcd(min_b[2]), .sec_bcd(sec_b[2]), .running(running[2]),
    .expired(expired[2]), .expire_pulse(xp[2]));
  countdown_timer #(.START_MIN(0),  .START_SEC(0)) u3 (.clock(clock), .reset(reset), .tick(tick[3]), .start(start[3]),
    .pause(pause[3]), .clear(clear[3]), .min_bcd(min_b[3]), .sec_bcd(sec_b[3]), .running(running[3]),
    .expired(expired[3]), .expire_pulse(xp[3]));
  countdown_timer #(.START_MIN(1),  .START_SEC(0)) u4 (.clock(clock), .reset(reset), .tick(tick[4]), .start(start[4]),
    .pause(pause[4]), .clear(clear[4]), .min_bcd(min_b[4]), .sec_bcd(sec_b[4]), .running(running[4]),
    .expired(expired[4]), .expire_pulse(xp[4]));

  // Inputs set before this are sampled at the edge; outputs read after it.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cyc(); reset = 1'b0;
    checks++; if ({min_b[0], sec_b[0]} !== 16'h0200) begin errors++; $display("FAIL reset_val u0: got %h want 0200", {min_b[0], sec_b[0]}); end
    checks++; if ({min_b[3], sec_b[3]} !== 16'h0000) begin errors++; $display("FAIL reset_val u3: got %h want 0000", {min_b[3], sec_b[3]}); end
    checks++; if (running !== 5'b0 || expired !== 5'b0 || xp !== 5'b0) begin errors++;
      $display("FAIL reset_flags: run=%b exp=%b xp=%b want all 0", running, expired, xp); end
  endtask

  task automatic test_basic;
    start[0] = 1'b1; cyc(); start[0] = 1'b0;
    checks++; if (running[0] !== 1'b1 || {min_b[0], sec_b[0]} !== 16'h0200) begin errors++;
      $display("FAIL start: run=%b val=%h want 1 0200", running[0], {min_b[0], sec_b[0]}); end
    tick[0] = 1'b1; cyc(); tick[0] = 1'b0;
    checks++; if ({min_b[0], sec_b[0]} !== 16'h0159 || running[0] !== 1'b1) begin errors++;
      $display("FAIL first_tick: val=%h run=%b want 0159 1", {min_b[0], sec_b[0]}, running[0]); end
    cyc();
    checks++; if ({min_b[0], sec_b[0]} !== 16'h0159) begin errors++; $display("FAIL hold_no_tick: got %h want 0159", {min_b[0], sec_b[0]}); end
    tick[0] = 1'b1; cyc(); tick[0] = 1'b0;
    checks++; if ({min_b[0], sec_b[0]} !== 16'h0158) begin errors++; $display("FAIL second_tick: got %h want 0158", {min_b[0], sec_b[0]}); end
  endtask

  task automatic test_expire;
    start[1] = 1'b1; cyc(); start[1] = 1'b0;
    tick[1] = 1'b1; cyc(); tick[1] = 1'b0;
    checks++; if ({min_b[1], sec_b[1]} !== 16'h0000 || expired[1] !== 1'b1 || xp[1] !== 1'b1 || running[1] !== 1'b0) begin errors++;
      $display("FAIL expire: val=%h exp=%b xp=%b run=%b want 0000 1 1 0", {min_b[1], sec_b[1]}, expired[1], xp[1], running[1]); end
    tick[1] = 1'b1; pause[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if ({min_b[1], sec_b[1]} !== 16'h0000 || xp[1] !== 1'b0 || expired[1] !== 1'b1) begin errors++;
        $display("FAIL expired_hold[%0d]: val=%h xp=%b exp=%b want 0000 0 1", i, {min_b[1], sec_b[1]}, xp[1], expired[1]); end
    end
    tick[1] = 1'b0; pause[1] = 1'b0;
  endtask

  task automatic test_pause;
    start[2] = 1'b1; cyc(); start[2] = 1'b0;
    tick[2] = 1'b1; pause[2] = 1'b1; cyc(); pause[2] = 1'b0;
    checks++; if ({min_b[2], sec_b[2]} !== 16'h0959 || running[2] !== 1'b0 || expired[2] !== 1'b0) begin errors++;
      $display("FAIL tick_pause: val=%h run=%b exp=%b want 0959 0 0", {min_b[2], sec_b[2]}, running[2], expired[2]); end
    cyc(5); tick[2] = 1'b0;
    checks++; if ({min_b[2], sec_b[2]} !== 16'h0959) begin errors++; $display("FAIL paused_hold: got %h want 0959", {min_b[2], sec_b[2]}); end
    start[2] = 1'b1; pause[2] = 1'b1; cyc(); pause[2] = 1'b0;
    checks++; if (running[2] !== 1'b0) begin errors++; $display("FAIL start_and_pause: run=%b want 0", running[2]); end
    cyc(); start[2] = 1'b0;
    checks++; if (running[2] !== 1'b1) begin errors++; $display("FAIL resume: run=%b want 1", running[2]); end
    tick[2] = 1'b1; cyc(); tick[2] = 1'b0;
    checks++; if ({min_b[2], sec_b[2]} !== 16'h0958) begin errors++; $display("FAIL resume_tick: got %h want 0958", {min_b[2], sec_b[2]}); end
  endtask

  task automatic test_zero_reload;
    start[3] = 1'b1; cyc(); start[3] = 1'b0;
    checks++; if (expired[3] !== 1'b1 || xp[3] !== 1'b1 || running[3] !== 1'b0) begin errors++;
      $display("FAIL zero_start: exp=%b xp=%b run=%b want 1 1 0", expired[3], xp[3], running[3]); end
    cyc();
    checks++; if (xp[3] !== 1'b0 || expired[3] !== 1'b1) begin errors++; $display("FAIL zero_pulse_once: xp=%b exp=%b want 0 1", xp[3], expired[3]); end
    start[3] = 1'b1; tick[3] = 1'b1; cyc(); start[3] = 1'b0;
    checks++; if (running[3] !== 1'b1 || expired[3] !== 1'b0 || {min_b[3], sec_b[3]} !== 16'h0000) begin errors++;
      $display("FAIL zero_restart: run=%b exp=%b val=%h want 1 0 0000", running[3], expired[3], {min_b[3], sec_b[3]}); end
    cyc(); tick[3] = 1'b0;
    checks++; if (expired[3] !== 1'b1 || xp[3] !== 1'b1 || running[3] !== 1'b0 || {min_b[3], sec_b[3]} !== 16'h0000) begin errors++;
      $display("FAIL zero_reexpire: exp=%b xp=%b run=%b val=%h want 1 1 0 0000", expired[3], xp[3], running[3], {min_b[3], sec_b[3]}); end
  endtask

  task automatic test_borrow;
    logic [15:0] want;
    start[4] = 1'b1; cyc(); start[4] = 1'b0;
    tick[4] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      want = {8'h00, 4'((60 - i) / 10), 4'((60 - i) % 10)};
      checks++; if ({min_b[4], sec_b[4]} !== want) begin errors++;
        $display("FAIL borrow_seq[%0d]: got %h want %h", i, {min_b[4], sec_b[4]}, want); end
    end
    tick[4] = 1'b0;
    checks++; if (expired[4] !== 1'b1 || xp[4] !== 1'b1) begin errors++; $display("FAIL borrow_expire: exp=%b xp=%b want 1 1", expired[4], xp[4]); end
    clear[4] = 1'b1; start[4] = 1'b1; cyc(); clear[4] = 1'b0; start[4] = 1'b0;
    checks++; if ({min_b[4], sec_b[4]} !== 16'h0100 || running[4] !== 1'b0 || expired[4] !== 1'b0 || xp[4] !== 1'b0) begin errors++;
      $display("FAIL clear: val=%h run=%b exp=%b xp=%b want 0100 0 0 0", {min_b[4], sec_b[4]}, running[4], expired[4], xp[4]); end
  endtask

  task automatic test_reset_midcount;
    // u0 sits at 01:58 running; 117 back-to-back ticks reach 00:01.
    tick[0] = 1'b1; cyc(117);
    checks++; if ({min_b[0], sec_b[0]} !== 16'h0001 || xp[0] !== 1'b0) begin errors++;
      $display("FAIL back_to_back: val=%h xp=%b want 0001 0", {min_b[0], sec_b[0]}, xp[0]); end
    reset = 1'b1; cyc(); reset = 1'b0; tick[0] = 1'b0;
    checks++; if ({min_b[0], sec_b[0]} !== 16'h0200 || running[0] !== 1'b0 || expired[0] !== 1'b0 || xp[0] !== 1'b0) begin errors++;
      $display("FAIL reset_mid: val=%h run=%b exp=%b xp=%b want 0200 0 0 0", {min_b[0], sec_b[0]}, running[0], expired[0], xp[0]); end
    cyc();
    checks++; if (xp[0] !== 1'b0 || running[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_after: xp=%b run=%b want 0 0", xp[0], running[0]); end
  endtask

  initial begin
    cyc(2);
    test_reset();
    test_basic();
    test_expire();
    test_pause();
    test_zero_reload();
    test_borrow();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
